// File: rtl/rv32i_types.sv
// ============================================================================
// Module   : rv32i_types
// Desc     : Shared types for the memory-side arbiters.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    ARB_OP_READ  = 1'b0,
    ARB_OP_WRITE = 1'b1
  } arb_op_t;

endpackage

`default_nettype wire

// File: rtl/arb_rr_pick.sv
// ============================================================================
// Module   : arb_rr_pick
// Desc     : Combinational round-robin priority encoder; scans from last+1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  always_comb begin
    int w_dist;
    int w_best;
    valid  = 1'b0;
    idx    = '0;
    w_dist = 0;
    w_best = NUM_PORTS;
    // Distance from the port after `last`; the nearest requester wins.
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dist = (i + NUM_PORTS - 1 - int'(last)) % NUM_PORTS;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        valid  = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
// ============================================================================
// Module   : mem_arbiter_rr
// Desc     : N-port round-robin arbiter in front of the cacheline adapter.
// Options  : MEM_ARB_STATS_EN adds per-port grant_count / wait_count outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter_rr
  import rv32i_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [LINE_W-1:0]           req_rdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [ADDR_W-1:0]           pmem_address,
  output logic [LINE_W-1:0]           pmem_wdata,
  input  logic [LINE_W-1:0]           pmem_rdata,
  input  logic                        pmem_resp
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]     grant_count,
  output logic [NUM_PORTS*32-1:0]     wait_count
`endif
);

  localparam int c_IDX_W = $clog2(NUM_PORTS);
  localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_PORTS - 1);

  arb_state_t          r_state;
  arb_op_t             r_op;
  logic [c_IDX_W-1:0]  r_grant;
  logic [c_IDX_W-1:0]  r_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;

  logic [NUM_PORTS-1:0] w_requesting;
  logic                 w_pick_valid;
  logic [c_IDX_W-1:0]   w_pick_idx;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [LINE_W-1:0]    w_sel_wdata;
  logic                 w_sel_write;

  assign w_requesting = req_read | req_write;

  arb_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (c_IDX_W)
  ) u_pick (
    .req   (w_requesting),
    .last  (r_last),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_write = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_pick_idx == c_IDX_W'(i)) begin
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*LINE_W +: LINE_W];
        w_sel_write = req_write[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_op    <= ARB_OP_READ;
      r_grant <= '0;
      r_last  <= c_LAST_RST;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_idx;
            r_op    <= w_sel_write ? ARB_OP_WRITE : ARB_OP_READ;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (pmem_resp) begin
            r_last  <= r_grant;
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Derived only from registers, so these fall with rst and never glitch on inputs.
  assign pmem_read    = (r_state == ARB_BUSY) && (r_op == ARB_OP_READ);
  assign pmem_write   = (r_state == ARB_BUSY) && (r_op == ARB_OP_WRITE);
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign req_rdata    = pmem_rdata;

  always_comb begin
    req_resp = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_resp[i] = (r_state == ARB_BUSY) && pmem_resp && (r_grant == c_IDX_W'(i));
    end
  end

`ifdef MEM_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
    logic [31:0] r_grant_cnt;
    logic [31:0] r_wait_cnt;
    logic        w_active;

    assign w_active = (r_state == ARB_BUSY) && (r_grant == c_IDX_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_grant_cnt <= '0;
        r_wait_cnt  <= '0;
      end else begin
        if (req_resp[gi])
          r_grant_cnt <= r_grant_cnt + 32'd1;
        if (w_requesting[gi] && !w_active)
          r_wait_cnt <= r_wait_cnt + 32'd1;
      end
    end

    assign grant_count[gi*32 +: 32] = r_grant_cnt;
    assign wait_count[gi*32 +: 32]  = r_wait_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
// ============================================================================
// Module   : tb_mem_arbiter_rr
// Desc     : Directed self-checking bench for mem_arbiter_rr (4 ports).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter_rr;
  import rv32i_types::*;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_read;
  logic [NP-1:0]     req_write;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*LW-1:0]  req_wdata;
  logic [NP-1:0]     req_resp;
  logic [LW-1:0]     req_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [AW-1:0]     pmem_address;
  logic [LW-1:0]     pmem_wdata;
  logic [LW-1:0]     pmem_rdata;
  logic              pmem_resp;
`ifdef MEM_ARB_STATS_EN
  logic [NP*32-1:0]  grant_count;
  logic [NP*32-1:0]  wait_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .LINE_W    (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_resp     (req_resp),
    .req_rdata    (req_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_count  (grant_count),
    .wait_count   (wait_count)
`endif
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr,
                          input rv32i_word a, input logic [LW-1:0] wd);
    req_read[p]            = rd;
    req_write[p]           = wr;
    req_addr[p*AW +: AW]   = a;
    req_wdata[p*LW +: LW]  = wd;
  endtask

  // Called in IDLE with port p's request already presented; it must win the next edge.
  task automatic serve(input string tag, input int p, input rv32i_word a,
                       input logic [LW-1:0] wd, input logic wr, input int lat,
                       input bit drop, input bit mutate);
    logic [LW-1:0] rdat;
    logic [NP-1:0] onehot;
    onehot    = '0;
    onehot[p] = 1'b1;
    rdat      = {(LW/32){a ^ 32'h5A5A_5A5A}};
    tick;
    check({tag, "_rd"},   pmem_read,    !wr);
    check({tag, "_wr"},   pmem_write,   wr);
    check({tag, "_addr"}, pmem_address, a);
    if (mutate) set_port(p, 1'b0, 1'b0, 32'h0000_FFFF, '0);
    repeat (lat - 1) tick;
    pmem_rdata = rdat;
    pmem_resp  = 1'b1;
    #1;
    check({tag, "_resp"},       req_resp,     onehot);
    check({tag, "_rdata"},      req_rdata,    rdat);
    check({tag, "_hold_addr"},  pmem_address, a);
    check({tag, "_hold_wdata"}, pmem_wdata,   wd);
    check({tag, "_hold_op"},    {pmem_write, pmem_read}, wr ? 2'b10 : 2'b01);
    if (drop) begin
      req_read[p]  = 1'b0;
      req_write[p] = 1'b0;
    end
    tick;
    pmem_resp = 1'b0;
    #1;
    check({tag, "_idle"}, {pmem_write, pmem_read}, 2'b00);
    check({tag, "_once"}, req_resp, '0);
  endtask

  initial begin
    rst        = 1'b1;
    req_read   = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // Reset: port 1 request held across reset release.
    set_port(1, 1'b1, 1'b0, 32'h40, '0);
    tick;
    tick;
    check("rst_pmem_read",  pmem_read,    1'b0);
    check("rst_pmem_write", pmem_write,   1'b0);
    check("rst_addr",       pmem_address, '0);
    check("rst_wdata",      pmem_wdata,   '0);
    check("rst_resp",       req_resp,     '0);
    rst = 1'b0;
    serve("reset_p1", 1, 32'h40, '0, 1'b0, 2, 1'b1, 1'b0);

    // Simultaneous reads after reset: port 0 first, then port 1.
    pulse_reset;
    set_port(0, 1'b1, 1'b0, 32'h100, '0);
    set_port(1, 1'b1, 1'b0, 32'h200, '0);
    serve("sim_p0", 0, 32'h100, '0, 1'b0, 3, 1'b1, 1'b0);
    serve("sim_p1", 1, 32'h200, '0, 1'b0, 3, 1'b1, 1'b0);

    // Fairness: all four ports request continuously; order 0,1,2,3,0.
    pulse_reset;
    for (int i = 0; i < NP; i++)
      set_port(i, 1'b1, 1'b0, 32'h1000 + 32'(i * 16), {(LW/32){32'hA0 + 32'(i)}});
    for (int k = 0; k <= NP; k++) begin
      int p;
      p = k % NP;
      serve($sformatf("fair%0d", k), p, 32'h1000 + 32'(p * 16),
            {(LW/32){32'hA0 + 32'(p)}}, 1'b0, 1, k == NP, 1'b0);
    end
    req_read = '0;

    // Write (read also set, write wins); address/data changed and request dropped mid-flight.
    set_port(1, 1'b1, 1'b1, 32'h80, {(LW/32){32'hDEAD_BEEF}});
    serve("wr_p1", 1, 32'h80, {(LW/32){32'hDEAD_BEEF}}, 1'b1, 3, 1'b1, 1'b1);

    // pmem_resp while idle must not produce a completion.
    pmem_resp = 1'b1;
    #1;
    check("idle_resp",      req_resp,  '0);
    check("idle_pmem_read", pmem_read, 1'b0);
    tick;
    pmem_resp = 1'b0;
    check("idle_stays", {pmem_write, pmem_read}, 2'b00);

    // Abort: async reset while busy, then a late pmem_resp.
    set_port(2, 1'b1, 1'b0, 32'h300, '0);
    tick;
    check("abort_busy", pmem_read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_read", pmem_read,    1'b0);
    check("abort_addr", pmem_address, '0);
    req_read[2] = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    pmem_resp = 1'b1;
    #1;
    check("late_resp", req_resp, '0);
    tick;
    pmem_resp = 1'b0;
    check("late_idle", {pmem_write, pmem_read}, 2'b00);

`ifdef MEM_ARB_STATS_EN
    // One port-0 grant with port 1 waiting: port 1 waits 3 cycles, port 0 one idle cycle.
    pulse_reset;
    check("stat_rst_grant", grant_count, '0);
    check("stat_rst_wait",  wait_count,  '0);
    set_port(0, 1'b1, 1'b0, 32'h500, '0);
    set_port(1, 1'b1, 1'b0, 32'h600, '0);
    serve("stat_p0", 0, 32'h500, '0, 1'b0, 1, 1'b1, 1'b0);
    serve("stat_p1", 1, 32'h600, '0, 1'b0, 1, 1'b1, 1'b0);
    check("stat_grant0", grant_count[0*32 +: 32], 32'd1);
    check("stat_grant1", grant_count[1*32 +: 32], 32'd1);
    check("stat_wait0",  wait_count[0*32 +: 32],  32'd1);
    check("stat_wait1",  wait_count[1*32 +: 32],  32'd3);
    check("stat_grant2", grant_count[2*32 +: 32], 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
